pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage WORD_SIZE pipeline (IF/ID/EX/MEM/WB).
//  Detects data hazards against in-flight writers in EX, MEM and WB.
//  Drives the per-stage write enables, the bubble/flush controls and the ALU operand forwarding selects.
//  Freezes the whole pipe on memory wait and on HLT retirement; keeps stall/flush perf counters.
// PARAMETERS
//  REG_ADDR_W   2    register-number width (4 GPRs, none hardwired to zero)
//  CNT_W        16   width of perf counters
//  MEM_TIMEOUT  64   max consecutive MEM_WAIT cycles before mem_timeout is set
// PORTS
//  clk            in   1           clock, rising edge
//  reset_n        in   1           synchronous, active-low reset
//  id_rs, id_rt   in   REG_ADDR_W  source regs of instruction in ID
//  id_use_rs/rt   in   1           ID instruction actually reads rs / rt
//  ex_reg_write   in   1           EX instruction writes a register
//  ex_dest        in   REG_ADDR_W  EX destination
//  ex_is_load     in   1           EX instruction is LWD (RegWriteSrc = memory)
//  mem_reg_write  in   1           MEM-stage write enable
//  mem_dest       in   REG_ADDR_W  MEM-stage destination
//  wb_reg_write   in   1           WB-stage write enable
//  wb_dest        in   REG_ADDR_W  WB-stage destination
//  branch_taken   in   1           EX resolved a taken branch/jump (redirect)
//  mem_access     in   1           MEM stage issues a data read/write this cycle
//  mem_ready      in   1           data memory completes the access this cycle
//  wb_halt        in   1           HLT instruction retiring in WB
//  pc_write       out  1           PC register update enable
//  ifid_write     out  1           IF/ID latch enable
//  ifid_flush     out  1           load NOP into IF/ID
//  idex_bubble    out  1           load NOP (all control 0) into ID/EX
//  back_write     out  1           enable for ID/EX, EX/MEM, MEM/WB latches
//  fwd_a, fwd_b   out  2           operand select: 00 regfile, 01 EX/MEM ALUOut, 10 WB WriteData
//  halted         out  1           pipeline permanently frozen by HLT
//  mem_timeout    out  1           sticky: MEM_WAIT exceeded MEM_TIMEOUT
//  stall_cnt      out  CNT_W       cycles with any stall or freeze, saturating
//  flush_cnt      out  CNT_W       taken-branch flushes, saturating
// BEHAVIOUR
//  - FSM states: RUN, MEM_WAIT, HALT.
//  - RUN -> MEM_WAIT on mem_access & ~mem_ready.
//  - MEM_WAIT -> RUN on mem_ready.
//  - any state -> HALT on wb_halt; HALT exits only via reset.
//  - Outputs are combinational from state and inputs; the FSM, wait timer and counters are registered.
//  - Priority, highest first: reset, HALT, MEM freeze, branch flush, load-use stall.
//  - Freeze (HALT, or mem_access & ~mem_ready in RUN/MEM_WAIT):
//    pc_write = ifid_write = back_write = 0; no flush; no bubble.
//  - Flush (branch_taken, not frozen): pc_write = 1, ifid_flush = 1, idex_bubble = 1.
//    Load-use is ignored in a flush cycle.
//  - Load-use (ex_is_load & ex_reg_write & ex_dest matches a used source):
//    pc_write = ifid_write = 0, idex_bubble = 1; always exactly 1 bubble.
//  - Forwarding select for each operand:
//    01 if mem_reg_write & mem_dest == src; else 10 if wb_reg_write & wb_dest == src; else 00.
//    EX/MEM has priority over WB.
//  - Wait timer: counts MEM_WAIT cycles and clears on exit.
//    mem_timeout sets when the timer reaches MEM_TIMEOUT and stays set until reset; the FSM keeps waiting.
//  - stall_cnt increments on any cycle with pc_write = 0.
//  - flush_cnt increments per flush.
//  - Both counters saturate at all-ones, no wrap.
//  - Reset values: FSM = RUN, counters 0, mem_timeout 0, halted 0.
//    During reset: pc_write = ifid_write = back_write = 0, flush 0, bubble 1, fwd 00.
//  - Reset mid-MEM_WAIT or mid-HALT returns to RUN on the next edge.
// CONFIGURATION
//  FORWARDING_EN defined: forwarding as above; stall only on load-use.
//  FORWARDING_EN undefined: fwd_a = fwd_b = 00 always.
//    Stall (same as load-use) on a match with any writer in EX, MEM or WB.
//    The register file is not write-before-read.
// STRUCTURE
//  Shared header pipe_ctrl_defs.v holds:
//    FSM state encodings (RUN/MEM_WAIT/HALT) and FWD_RF/FWD_EXMEM/FWD_WB codes.
//  Sub-module fwd_sel: one operand's match and select logic, instantiated twice (rs, rt).
// TESTING
//  - LWD r1 in EX, ID reads r1 -> 1 cycle with pc_write=0 and idex_bubble=1; stall_cnt +1.
//  - ADD r2 in MEM, ADD r2 in WB, ID reads r2 -> fwd_a=01 (EX/MEM wins), no stall.
//  - mem_access=1, mem_ready=0 for 3 cycles -> 3 frozen cycles.
//    With MEM_TIMEOUT=2, mem_timeout=1 and stays set.
//  - branch_taken with a simultaneous load-use -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1.
//  - wb_halt -> halted=1, all writes 0 indefinitely; reset_n=0 one cycle -> RUN, counters 0.
//  - Without FORWARDING_EN: WB writer r3, ID reads r3 -> 1-cycle stall, fwd_a=00.
//  - Saturation: force stall_cnt to all-ones by stalling -> stall_cnt holds at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard controller:
// FSM state encoding and operand-forwarding select codes.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_e;

   typedef logic [1:0] fwd_t;

   localparam fwd_t FWD_RF    = 2'b00;
   localparam fwd_t FWD_EXMEM = 2'b01;
   localparam fwd_t FWD_WB    = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 2,
   parameter int CNT_W      = 16
);
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_use_rs;
   logic                  id_use_rt;
   logic                  ex_reg_write;
   logic [REG_ADDR_W-1:0] ex_dest;
   logic                  ex_is_load;
   logic                  mem_reg_write;
   logic [REG_ADDR_W-1:0] mem_dest;
   logic                  wb_reg_write;
   logic [REG_ADDR_W-1:0] wb_dest;
   logic                  branch_taken;
   logic                  mem_access;
   logic                  mem_ready;
   logic                  wb_halt;

   logic                  pc_write;
   logic                  ifid_write;
   logic                  ifid_flush;
   logic                  idex_bubble;
   logic                  back_write;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;
   logic                  halted;
   logic                  mem_timeout;
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      flush_cnt;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt,
      output ex_reg_write, ex_dest, ex_is_load,
      output mem_reg_write, mem_dest,
      output wb_reg_write, wb_dest,
      output branch_taken, mem_access, mem_ready, wb_halt,
      input  pc_write, ifid_write, ifid_flush,
      input  idex_bubble, back_write,
      input  fwd_a, fwd_b, halted, mem_timeout,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt,
      input  ex_reg_write, ex_dest, ex_is_load,
      input  mem_reg_write, mem_dest,
      input  wb_reg_write, wb_dest,
      input  branch_taken, mem_access, mem_ready, wb_halt,
      output pc_write, ifid_write, ifid_flush,
      output idex_bubble, back_write,
      output fwd_a, fwd_b, halted, mem_timeout,
      output stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand writer match: forwarding select and hazard flag.
// Behaviour depends on FORWARDING_EN.
module fwd_sel
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 2
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  use_src,
   input  logic                  ex_reg_write,
   input  logic [REG_ADDR_W-1:0] ex_dest,
   input  logic                  ex_is_load,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   output fwd_t                  fwd,
   output logic                  hazard
);

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   assign ex_hit  = ex_reg_write & (ex_dest == src);
   assign mem_hit = mem_reg_write & (mem_dest == src);
   assign wb_hit  = wb_reg_write & (wb_dest == src);

`ifdef FORWARDING_EN
   // The younger EX/MEM value shadows the older WB value.
   always_comb begin
      fwd = FWD_RF;
      if (mem_hit)
         fwd = FWD_EXMEM;
      else if (wb_hit)
         fwd = FWD_WB;
   end

   assign hazard = use_src & ex_is_load & ex_hit;
`else
   logic unused_load;

   assign unused_load = ex_is_load;
   assign fwd         = FWD_RF;
   // No bypass and no write-before-read: wait out every writer.
   assign hazard      = use_src & (ex_hit | mem_hit | wb_hit);
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush/freeze control, forwarding,
// perf counters. Forwarding is enabled by defining FORWARDING_EN.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 2,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input logic              clk,
   input logic              reset_n,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW:0] TMO = (TW + 1)'(MEM_TIMEOUT);

   state_e           state;
   state_e           state_nx;
   fwd_t             fa;
   fwd_t             fb;
   logic             haz_a;
   logic             haz_b;
   logic             frozen;
   logic             rst_c;
   logic             frz_c;
   logic             fls_c;
   logic             stl_c;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             back_write;
   logic [TW-1:0]    timer;
   logic [TW:0]      timer_inc;
   logic             tmo_q;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .src           (bus.id_rs),
      .use_src       (bus.id_use_rs),
      .ex_reg_write  (bus.ex_reg_write),
      .ex_dest       (bus.ex_dest),
      .ex_is_load    (bus.ex_is_load),
      .mem_reg_write (bus.mem_reg_write),
      .mem_dest      (bus.mem_dest),
      .wb_reg_write  (bus.wb_reg_write),
      .wb_dest       (bus.wb_dest),
      .fwd           (fa),
      .hazard        (haz_a)
   );

   fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .src           (bus.id_rt),
      .use_src       (bus.id_use_rt),
      .ex_reg_write  (bus.ex_reg_write),
      .ex_dest       (bus.ex_dest),
      .ex_is_load    (bus.ex_is_load),
      .mem_reg_write (bus.mem_reg_write),
      .mem_dest      (bus.mem_dest),
      .wb_reg_write  (bus.wb_reg_write),
      .wb_dest       (bus.wb_dest),
      .fwd           (fb),
      .hazard        (haz_b)
   );

   assign frozen = (state == HALT) |
                   (bus.mem_access & ~bus.mem_ready);

   // Mutually exclusive cases in priority order.
   assign rst_c = ~reset_n;
   assign frz_c = reset_n & frozen;
   assign fls_c = reset_n & ~frozen & bus.branch_taken;
   assign stl_c = reset_n & ~frozen & ~bus.branch_taken &
                  (haz_a | haz_b);

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      back_write  = 1'b1;
      unique case (1'b1)
         rst_c: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            back_write  = 1'b0;
            idex_bubble = 1'b1;
         end
         frz_c: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            back_write = 1'b0;
         end
         fls_c: begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end
         stl_c: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nx = state;
      if (bus.wb_halt) begin
         state_nx = HALT;
      end else begin
         unique case (state)
            RUN:
               if (bus.mem_access & ~bus.mem_ready)
                  state_nx = MEM_WAIT;
            MEM_WAIT:
               if (bus.mem_ready)
                  state_nx = RUN;
            HALT:    state_nx = HALT;
            default: state_nx = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= RUN;
      else
         state <= state_nx;
   end

   assign timer_inc = {1'b0, timer} + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         timer <= '0;
         tmo_q <= 1'b0;
      end else if (state == MEM_WAIT) begin
         if (timer_inc <= TMO)
            timer <= timer_inc[TW-1:0];
         if (timer_inc >= TMO)
            tmo_q <= 1'b1;
      end else begin
         timer <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_write && stall_q != '1)
            stall_q <= stall_q + 1'b1;
         if (ifid_flush && flush_q != '1)
            flush_q <= flush_q + 1'b1;
      end
   end

   assign bus.pc_write    = pc_write;
   assign bus.ifid_write  = ifid_write;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_bubble = idex_bubble;
   assign bus.back_write  = back_write;
   assign bus.fwd_a       = rst_c ? FWD_RF : fa;
   assign bus.fwd_b       = rst_c ? FWD_RF : fb;
   assign bus.halted      = (state == HALT);
   assign bus.mem_timeout = tmo_q;
   assign bus.stall_cnt   = stall_q;
   assign bus.flush_cnt   = flush_q;

endmodule
